reaction_responder: RTL and testbench

- Automatic player for the LED/KEY reaction-time game, used for board self-test and for regression of the game logic without a human.
- Watches the game's one-hot LEDG stimulus and drives the matching active-low KEY line after a programmable reaction delay.
- Holds the key for a fixed time, then waits for the stimulus to clear before re-arming.
- Counts completed responses for display on the 4-digit seven-segment path.

---
 rtl/reaction_responder.sv | 156 +++++++++++++++
 tb/tb_reaction_responder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_responder.sv
// reaction_responder: automatic player for the LEDG/KEY reaction game.
// Presses the lit key after a programmable delay and counts responses.
module reaction_responder #(
    parameter int DELAY_STEP  = 5000000,
    parameter int HOLD_CYCLES = 2500000
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        enable,
    input  logic [7:0]  ledg_in,
    input  logic [3:0]  delay_sel,
    output logic [3:0]  key_out,
    output logic        busy,
    output logic        bad_pattern,
    output logic [13:0] responses
);

    localparam int DW = $clog2(16 * DELAY_STEP + 1);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_PRESS,
        S_RELEASE
    } state_t;

    state_t          r_state;
    state_t          w_state_n;
    logic [1:0]      r_tgt;
    logic [7:0]      r_pat;
    logic [3:0]      r_sel;
    logic [DW-1:0]   r_dcnt;
    logic [HW-1:0]   r_hcnt;
    logic [3:0]      r_key;
    logic            r_busy;
    logic            r_bad;
    logic [13:0]     r_resp;

    logic [1:0]      w_idx;
    logic            w_valid;
    logic            w_nz;
    logic [DW-1:0]   w_dly;
    logic [3:0]      w_press_mask;
    logic            w_latch;
    logic            w_bad_set;
    logic            w_done;

    assign w_nz         = |ledg_in;
    assign w_dly        = DW'((32'(r_sel) + 32'd1) * 32'(DELAY_STEP));
    assign w_press_mask = 4'b1111 ^ (4'b0001 << r_tgt);

    assign key_out     = r_key;
    assign busy        = r_busy;
    assign bad_pattern = r_bad;
    assign responses   = r_resp;

    // Decode the one-hot stimulus into a key index and a validity flag.
    always_comb begin
        w_idx   = 2'd0;
        w_valid = 1'b1;
        case (ledg_in)
            8'h02:   w_idx = 2'd0;
            8'h08:   w_idx = 2'd1;
            8'h20:   w_idx = 2'd2;
            8'h80:   w_idx = 2'd3;
            default: w_valid = 1'b0;
        endcase
    end

    // Next-state logic; a stimulus change in WAIT outranks delay expiry.
    always_comb begin
        w_state_n = r_state;
        w_latch   = 1'b0;
        w_bad_set = 1'b0;
        w_done    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (enable && w_nz) begin
                    if (w_valid) begin
                        w_state_n = S_WAIT;
                        w_latch   = 1'b1;
                    end else begin
                        w_bad_set = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (!enable || !w_nz) begin
                    w_state_n = S_IDLE;
                end else if (!w_valid) begin
                    w_bad_set = 1'b1;
                    w_state_n = S_IDLE;
                end else if (ledg_in != r_pat) begin
                    w_latch = 1'b1;
                end else if (r_dcnt == w_dly) begin
                    w_state_n = S_PRESS;
                end
            end
            S_PRESS: begin
                if (!enable) begin
                    w_state_n = S_IDLE;
                end else if (r_hcnt == HW'(HOLD_CYCLES - 1)) begin
                    w_state_n = S_RELEASE;
                    w_done    = 1'b1;
                end
            end
            S_RELEASE: begin
                if (!enable || !w_nz) begin
                    w_state_n = S_IDLE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_tgt   <= 2'd0;
            r_pat   <= 8'd0;
            r_sel   <= 4'd0;
            r_dcnt  <= '0;
            r_hcnt  <= '0;
            r_key   <= 4'b1111;
            r_busy  <= 1'b0;
            r_bad   <= 1'b0;
            r_resp  <= 14'd0;
        end else begin
            r_state <= w_state_n;
            if (w_latch) begin
                r_tgt  <= w_idx;
                r_pat  <= ledg_in;
                r_sel  <= delay_sel;
                r_dcnt <= '0;
            end else if (w_state_n == S_WAIT) begin
                r_dcnt <= r_dcnt + 1'b1;
            end
            if (r_state == S_PRESS && w_state_n == S_PRESS) begin
                r_hcnt <= r_hcnt + 1'b1;
            end else begin
                r_hcnt <= '0;
            end
            r_key  <= (w_state_n == S_PRESS) ? w_press_mask : 4'b1111;
            r_busy <= (w_state_n != S_IDLE);
            if (w_bad_set) begin
                r_bad <= 1'b1;
            end
            if (w_done) begin
                r_resp <= (r_resp == 14'd9999) ? 14'd0 : r_resp + 14'd1;
            end
        end
    end

endmodule

// File: tb/tb_reaction_responder.sv
// tb_reaction_responder: scoreboard bench for reaction_responder.
// Expected output events are queued by stimulus and matched by monitors.
module tb_reaction_responder;

    typedef struct {
        int         cyc;
        logic [3:0] key;
        logic       busy;
        logic       bad;
        logic [13:0] resp;
    } ev_t;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  ledg = 8'd0;
    logic [3:0]  delay_sel = 4'd0;
    logic [3:0]  key_out;
    logic        busy;
    logic        bad_pattern;
    logic [13:0] responses;

    logic        en2 = 1'b0;
    logic [7:0]  ledg2 = 8'd0;
    logic [3:0]  key2;
    logic        busy2;
    logic        bad2;
    logic [13:0] resp2;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int m_resp = 0;
    logic m_bad = 1'b0;
    int m2 = 0;
    bit mon_on = 1'b0;
    bit first = 1'b1;

    ev_t q[$];
    int  q2[$];

    logic [3:0]  p_key;
    logic        p_busy;
    logic        p_bad;
    logic [13:0] p_resp;
    logic [13:0] p_resp2;

    reaction_responder #(
        .DELAY_STEP(10),
        .HOLD_CYCLES(4)
    ) dut (
        .CLOCK_50(clk),
        .RESET(RESET),
        .enable(enable),
        .ledg_in(ledg),
        .delay_sel(delay_sel),
        .key_out(key_out),
        .busy(busy),
        .bad_pattern(bad_pattern),
        .responses(responses)
    );

    reaction_responder #(
        .DELAY_STEP(1),
        .HOLD_CYCLES(1)
    ) dut2 (
        .CLOCK_50(clk),
        .RESET(RESET),
        .enable(en2),
        .ledg_in(ledg2),
        .delay_sel(4'd0),
        .key_out(key2),
        .busy(busy2),
        .bad_pattern(bad2),
        .responses(resp2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Main monitor: every change of the observed outputs is one event.
    always @(negedge clk) begin
        if (mon_on) begin
            if (first || key_out !== p_key || busy !== p_busy ||
                bad_pattern !== p_bad || responses !== p_resp) begin
                first = 1'b0;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected: cyc=%0d key=%b busy=%b bad=%b resp=%0d",
                             cyc, key_out, busy, bad_pattern, responses);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    if (e.cyc != cyc || e.key !== key_out || e.busy !== busy ||
                        e.bad !== bad_pattern || e.resp !== responses) begin
                        errors++;
                        $display("FAIL event: got cyc=%0d key=%b busy=%b bad=%b resp=%0d want cyc=%0d key=%b busy=%b bad=%b resp=%0d",
                                 cyc, key_out, busy, bad_pattern, responses,
                                 e.cyc, e.key, e.busy, e.bad, e.resp);
                    end
                end
            end
            p_key  = key_out;
            p_busy = busy;
            p_bad  = bad_pattern;
            p_resp = responses;
        end
    end

    // Wrap monitor: every change of the fast instance's count is checked.
    always @(negedge clk) begin
        if (mon_on) begin
            if (resp2 !== p_resp2) begin
                checks++;
                if (q2.size() == 0) begin
                    errors++;
                    $display("FAIL wrap unexpected: resp=%0d", resp2);
                end else begin
                    int w;
                    w = q2.pop_front();
                    if (resp2 !== 14'(w)) begin
                        errors++;
                        $display("FAIL wrap: got resp=%0d want %0d", resp2, w);
                    end
                end
            end
            p_resp2 = resp2;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic push(input int c, input logic [3:0] k, input logic b);
        ev_t e;
        e.cyc  = c;
        e.key  = k;
        e.busy = b;
        e.bad  = m_bad;
        e.resp = 14'(m_resp);
        q.push_back(e);
    endtask

    function automatic logic [3:0] mask_of(input logic [7:0] pat);
        case (pat)
            8'd2:    return 4'b1110;
            8'd8:    return 4'b1101;
            8'd32:   return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    // Full press: arm, press after (sel+1)*10+1 edges, hold 4, clear.
    task automatic do_press(input logic [7:0] pat, input logic [3:0] sel,
                            input int hold);
        int t;
        int d;
        ledg = pat;
        delay_sel = sel;
        t = cyc + 1;
        d = (int'(sel) + 1) * 10;
        push(t, 4'b1111, 1'b1);
        push(t + d + 1, mask_of(pat), 1'b1);
        m_resp = (m_resp + 1) % 10000;
        push(t + d + 5, 4'b1111, 1'b1);
        wait_to(t + d + 5 + hold);
        ledg = 8'd0;
        push(cyc + 1, 4'b1111, 1'b0);
        wait_to(cyc + 3);
    endtask

    initial begin
        int t;
        int c;
        step();
        step();
        step();
        RESET = 1'b0;
        push(cyc, 4'b1111, 1'b0);
        p_resp2 = resp2;
        mon_on = 1'b1;
        step();
        enable = 1'b1;

        // basic press, then delay select with stimulus held in RELEASE
        do_press(8'd8, 4'd0, 5);
        do_press(8'd128, 4'd3, 40);
        do_press(8'd128, 4'd3, 0);

        // restart in WAIT on a new valid pattern
        ledg = 8'd2;
        delay_sel = 4'd0;
        t = cyc + 1;
        push(t, 4'b1111, 1'b1);
        wait_to(t + 4);
        ledg = 8'd32;
        c = cyc + 1;
        push(c + 11, 4'b1011, 1'b1);
        m_resp = m_resp + 1;
        push(c + 15, 4'b1111, 1'b1);
        wait_to(c + 20);
        ledg = 8'd0;
        push(cyc + 1, 4'b1111, 1'b0);
        wait_to(cyc + 3);

        // abort in WAIT
        ledg = 8'd2;
        t = cyc + 1;
        push(t, 4'b1111, 1'b1);
        wait_to(t + 4);
        ledg = 8'd0;
        push(t + 5, 4'b1111, 1'b0);
        wait_to(t + 40);

        // invalid pattern sets a sticky flag
        ledg = 8'd3;
        t = cyc + 1;
        m_bad = 1'b1;
        push(t, 4'b1111, 1'b0);
        wait_to(t + 5);
        ledg = 8'd0;
        wait_to(cyc + 10);

        // enable drop in the second PRESS cycle
        ledg = 8'd8;
        t = cyc + 1;
        push(t, 4'b1111, 1'b1);
        push(t + 11, 4'b1101, 1'b1);
        wait_to(t + 12);
        enable = 1'b0;
        ledg = 8'd0;
        push(t + 13, 4'b1111, 1'b0);
        wait_to(t + 20);
        enable = 1'b1;
        step();

        // reset mid-press
        ledg = 8'd8;
        t = cyc + 1;
        push(t, 4'b1111, 1'b1);
        push(t + 11, 4'b1101, 1'b1);
        wait_to(t + 12);
        RESET = 1'b1;
        ledg = 8'd0;
        m_resp = 0;
        m_bad = 1'b0;
        push(t + 13, 4'b1111, 1'b0);
        wait_to(t + 15);
        RESET = 1'b0;
        wait_to(cyc + 3);

        do_press(8'd32, 4'd1, 3);

        // 10000 fast presses on the second instance
        en2 = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            m2 = (m2 + 1) % 10000;
            q2.push_back(m2);
            ledg2 = 8'd2;
            step();
            step();
            step();
            ledg2 = 8'd0;
            step();
            step();
        end
        step();
        step();

        checks++;
        if (q.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL pending: main=%0d wrap=%0d want 0 0", q.size(), q2.size());
        end
        checks++;
        if (resp2 !== 14'd0 || key2 !== 4'b1111 || busy2 !== 1'b0 || bad2 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end: resp=%0d key=%b busy=%b bad=%b want 0 1111 0 0",
                     resp2, key2, busy2, bad2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
